instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//   Producer side of the instruction register: holds the PC, fetches 32-bit words from instruction memory
//   (req/gnt + rvalid), and drives if_instr / if_ir_wr_en into the IR. Honours decode stall and PC
//   redirects (branch/jump/trap). Runs one outstanding memory request at a time.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC loaded on reset; must be word aligned
//   IDLE_CYCLES  1              cycles spent in IDLE after reset deasserts before the first request (>=1)
// PORTS
//   if_clk          in   1   single clock; all state changes on posedge
//   if_rst          in   1   reset: synchronous, active-high
//   imem_req        out  1   fetch request valid
//   imem_addr       out  32  fetch address (= pc while imem_req)
//   imem_gnt        in   1   memory accepts request this cycle
//   imem_rvalid     in   1   read data valid
//   imem_rdata      in   32  instruction word
//   if_instr        out  32  instruction to IR (ir_in)
//   if_ir_wr_en     out  1   IR write strobe (ir_wr_en); one cycle per delivered instruction
//   if_pc           out  32  PC of the word on if_instr
//   if_stall        in   1   decode cannot accept; suppresses if_ir_wr_en
//   if_redirect     in   1   load new PC, flush in-flight fetch
//   if_redirect_pc  in   32  redirect target
//   if_misaligned   out  1   sticky fault: redirect target[1:0] != 0
// BEHAVIOUR
//   Reset (if_rst=1 at posedge): pc=RESET_PC, state=IDLE, imem_req=0, if_ir_wr_en=0, if_instr=0, if_pc=0,
//     if_misaligned=0, buffer empty, discard flag clear. Reset overrides every other input.
//   States: IDLE, REQ, WAIT, HOLD, FAULT.
//   IDLE: count IDLE_CYCLES, then REQ.
//   REQ: imem_req=1, imem_addr=pc. imem_gnt=1 -> WAIT. Address stable until granted.
//   WAIT: imem_req=0. imem_rvalid=1 -> capture rdata into hold buffer with pc -> HOLD. rvalid outside WAIT ignored.
//   HOLD: if_instr/if_pc driven from buffer (registered). if_ir_wr_en = !if_stall (combinational on registered
//     buffer). On a cycle with if_ir_wr_en=1: pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), buffer empties, -> REQ.
//     if_stall=1 holds buffer and pc indefinitely; if_instr stable.
//   Latency: gnt in cycle N, rvalid in N+k -> if_ir_wr_en earliest N+k+1; next imem_req earliest N+k+2.
//   if_ir_wr_en is never high outside HOLD; if_instr holds last value otherwise.
//   Redirect (highest priority after reset), aligned target:
//     REQ, no gnt: pc<=target, stay REQ (new address next cycle).
//     REQ with gnt same cycle, or WAIT: pc<=target, set discard flag, go/stay WAIT; the response is dropped
//       (no buffer load), then REQ at target. Redirect coincident with rvalid: that rvalid dropped, -> REQ.
//     HOLD: buffer dropped, if_ir_wr_en forced 0 that cycle, pc<=target, -> REQ.
//     IDLE: pc<=target, idle count continues. Later redirect overrides an earlier one (last target wins).
//   Misaligned target: -> FAULT (if an access is outstanding, its response is still discarded),
//     if_misaligned=1, imem_req=0, no writes. FAULT exits only on
//     reset or an aligned redirect (-> REQ, if_misaligned cleared).
// STRUCTURE
//   rv32i_pkg: fetch state enum (IF_IDLE..IF_FAULT), XLEN=32, INSTR_BYTES=4 constant.
//   One sub-module natural: if_hold_buffer (32b instr + 32b pc + valid, load/clear/hold). PC and FSM in top.
// TESTING
//   Reset then zero-wait memory (gnt same cycle, rvalid next) -> addrs 0,4,8; if_instr matches each rdata; one wr_en per word.
//   if_stall=1 for 5 cycles while in HOLD with 32'h00A00093 -> if_ir_wr_en=0, if_instr stable; release -> one strobe, then req to pc+4.
//   Redirect to 32'h0000_0100 while WAIT, then rvalid 32'hDEADBEEF -> no wr_en for DEADBEEF; next imem_addr=0x100.
//   Redirect to 32'h0000_0102 -> if_misaligned=1, imem_req=0 for 10 cycles; redirect 0x200 -> fault clears, imem_addr=0x200.
//   RESET_PC=32'hFFFF_FFFC: one fetch then next imem_addr=0 (wrap).
//   if_rst asserted mid-WAIT with rvalid same cycle -> all outputs reset values next cycle, no wr_en; refetch from RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared fetch-side definitions: machine word width, instruction size and
// the fetch FSM state encoding.
package rv32i_pkg;

  localparam int XLEN = 32;

  // Every instruction is one 32-bit word, so the sequential PC step is 4.
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  typedef enum logic [2:0] {
    IF_IDLE  = 3'd0,
    IF_REQ   = 3'd1,
    IF_WAIT  = 3'd2,
    IF_HOLD  = 3'd3,
    IF_FAULT = 3'd4
  } if_state_e;

  // A fetch target is legal only if it sits on a word boundary.
  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// Single-entry holding register between instruction memory and the IR.
// Keeps the fetched word plus the PC it was fetched from. Clearing only
// drops the valid bit, so the data outputs keep their last value.
module if_hold_buffer
  import rv32i_pkg::*;
(
  input  logic            if_clk,
  input  logic            if_rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] buf_instr,
  output logic [XLEN-1:0] buf_pc,
  output logic            buf_valid
);

  logic [XLEN-1:0] instr_reg;
  logic [XLEN-1:0] pc_reg;
  logic            valid_reg;

  // Load takes priority over clear; a cleared entry keeps its data visible.
  always_ff @(posedge if_clk) begin
    if (if_rst) begin
      instr_reg <= '0;
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      instr_reg <= load_instr;
      pc_reg    <= load_pc;
      valid_reg <= 1'b1;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end
  end

  assign buf_instr = instr_reg;
  assign buf_pc    = pc_reg;
  assign buf_valid = valid_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding word fetch at
// a time over a req/gnt + rvalid interface, parks the returned word in a
// hold buffer and strobes it into the IR when decode is not stalled.
// Redirects reload the PC and flush whatever fetch is in flight; a
// misaligned redirect target parks the unit in a sticky fault state.
module instruction_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     IDLE_CYCLES = 1
) (
  input  logic            if_clk,
  input  logic            if_rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_instr,
  output logic            if_ir_wr_en,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_stall,
  input  logic            if_redirect,
  input  logic [XLEN-1:0] if_redirect_pc,
  output logic            if_misaligned
);

  localparam int unsigned     CNT_W     = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  if_state_e       state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [CNT_W-1:0] idle_cnt_reg;
  logic            discard_reg;
  logic            misaligned_reg;

  logic            target_ok;
  logic            buf_load;
  logic            buf_clear;
  logic            buf_valid;
  logic [XLEN-1:0] buf_instr;
  logic [XLEN-1:0] buf_pc;
  logic            wr_en;

  assign target_ok = is_word_aligned(if_redirect_pc);

  // IR strobe and hold-buffer control: a word is delivered only from HOLD,
  // only when decode can take it and no redirect is flushing it.
  always_comb begin
    wr_en     = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if (!if_rst) begin
      wr_en     = (state_reg == IF_HOLD) && buf_valid && !if_stall && !if_redirect;
      buf_load  = (state_reg == IF_WAIT) && imem_rvalid && !discard_reg && !if_redirect;
      buf_clear = (state_reg == IF_HOLD) && (wr_en || if_redirect);
    end
  end

  // Fetch FSM together with PC, idle counter, discard flag and fault flag.
  always_ff @(posedge if_clk) begin
    if (if_rst) begin
      state_reg      <= IF_IDLE;
      pc_reg         <= RESET_PC;
      idle_cnt_reg   <= '0;
      discard_reg    <= 1'b0;
      misaligned_reg <= 1'b0;
    end else if (if_redirect && !target_ok) begin
      // Misaligned target: stop fetching. Keep tracking any response still
      // owed by memory so it can be swallowed rather than delivered.
      state_reg      <= IF_FAULT;
      misaligned_reg <= 1'b1;
      case (state_reg)
        IF_REQ:   discard_reg <= imem_gnt;
        IF_WAIT:  discard_reg <= !imem_rvalid;
        IF_FAULT: discard_reg <= discard_reg && !imem_rvalid;
        default:  discard_reg <= 1'b0;
      endcase
    end else begin
      case (state_reg)
        IF_IDLE: begin
          if (if_redirect) begin
            pc_reg <= if_redirect_pc;
          end
          if (idle_cnt_reg == IDLE_LAST) begin
            state_reg <= IF_REQ;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end
        IF_REQ: begin
          if (if_redirect) begin
            pc_reg <= if_redirect_pc;
            if (imem_gnt) begin
              // The granted access is now stale; drop its response.
              discard_reg <= 1'b1;
              state_reg   <= IF_WAIT;
            end
          end else if (imem_gnt) begin
            state_reg <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (if_redirect) begin
            pc_reg <= if_redirect_pc;
            if (imem_rvalid) begin
              discard_reg <= 1'b0;
              state_reg   <= IF_REQ;
            end else begin
              discard_reg <= 1'b1;
            end
          end else if (imem_rvalid) begin
            discard_reg <= 1'b0;
            state_reg   <= discard_reg ? IF_REQ : IF_HOLD;
          end
        end
        IF_HOLD: begin
          if (if_redirect) begin
            pc_reg    <= if_redirect_pc;
            state_reg <= IF_REQ;
          end else if (!if_stall) begin
            pc_reg    <= pc_reg + INSTR_BYTES;
            state_reg <= IF_REQ;
          end
        end
        IF_FAULT: begin
          if (if_redirect) begin
            pc_reg         <= if_redirect_pc;
            misaligned_reg <= 1'b0;
            // If a stale response is still owed, wait it out first so that
            // only one access is ever outstanding.
            if (discard_reg && !imem_rvalid) begin
              state_reg <= IF_WAIT;
            end else begin
              discard_reg <= 1'b0;
              state_reg   <= IF_REQ;
            end
          end else if (imem_rvalid) begin
            discard_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IF_IDLE;
        end
      endcase
    end
  end

  if_hold_buffer u_hold_buffer (
    .if_clk     (if_clk),
    .if_rst     (if_rst),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_instr (imem_rdata),
    .load_pc    (pc_reg),
    .buf_instr  (buf_instr),
    .buf_pc     (buf_pc),
    .buf_valid  (buf_valid)
  );

  assign imem_req      = (state_reg == IF_REQ);
  assign imem_addr     = pc_reg;
  assign if_instr      = buf_instr;
  assign if_pc         = buf_pc;
  assign if_ir_wr_en   = wr_en;
  assign if_misaligned = misaligned_reg;

endmodule
